// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream and instruction memory write port bundle
//
// Signals:
//   in_data  [7:0]  stream byte                           (master -> slave)
//   in_valid        in_data is valid                      (master -> slave)
//   in_ready        loader accepts a byte this cycle      (slave -> master)
//   im_we           instruction memory write enable pulse (slave -> master)
//   im_addr [31:0]  word-aligned byte address of write    (slave -> master)
//   im_wd   [31:0]  word to write                         (slave -> master)
// master: stream source plus instruction memory side; slave: imem_loader.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wd;

  modport master (
    output in_data, in_valid,
    input  in_ready, im_we, im_addr, im_wd
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, im_we, im_addr, im_wd
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for instruction memory
//
// Accepts a stream of: 2-byte little-endian word count N, 4N little-endian
// data bytes and, with IMEM_CHECKSUM_EN defined, one XOR checksum byte.
// Each assembled word is written to consecutive word-aligned addresses.
// The CPU is held in reset until the load completes.
//
// Parameters:
//   ADDR_WIDTH  word-address bits (2^ADDR_WIDTH words of instruction memory)
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   bus        imem_loader_if.slave: in_data/in_valid/in_ready stream,
//              im_we/im_addr/im_wd write port
//   cpu_reset  high until the load has completed successfully
//   done       load completed successfully
//   error      load rejected (count too large or checksum mismatch)
// Configuration macro: IMEM_CHECKSUM_EN enables the trailing checksum byte.
module imem_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    WRITE,
`ifdef IMEM_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

  // State entered once all words are written (or N == 0).
`ifdef IMEM_CHECKSUM_EN
  localparam state_t LOAD_END = CSUM;
`else
  localparam state_t LOAD_END = DONE;
`endif

  localparam logic [16:0]         MAX_WORDS = 17'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] IDX_ONE   = 1;

  state_t              state;
  state_t              state_nx;
  logic [7:0]          count_lo;
  logic [15:0]         count;
  logic [31:0]         word_q;
  logic [ADDR_WIDTH:0] word_idx;   // one extra bit so N = 2^ADDR_WIDTH fits
  logic [1:0]          byte_cnt;
  logic                accepting;
  logic                accept;
  logic [16:0]         hdr_count;
  logic                last_word;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  always_comb begin
    accepting = 1'b0;
    case (state)
      HDR0, HDR1, DATA: accepting = 1'b1;
`ifdef IMEM_CHECKSUM_EN
      CSUM:             accepting = 1'b1;
`endif
      default:          accepting = 1'b0;
    endcase
  end

  // Ready depends only on state and reset, never on in_valid.
  assign bus.in_ready = accepting && !reset;
  assign accept       = bus.in_valid && bus.in_ready;

  // Full count as seen while the high header byte is on the bus.
  assign hdr_count = {1'b0, bus.in_data, count_lo};
  assign last_word = (17'(word_idx) + 17'd1) == {1'b0, count};

  assign bus.im_we   = (state == WRITE);
  assign bus.im_addr = 32'({word_idx, 2'b00});
  assign bus.im_wd   = word_q;
  assign cpu_reset   = (state != DONE);
  assign done        = (state == DONE);
  assign error       = (state == ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HDR0;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      HDR0: if (accept) state_nx = HDR1;
      HDR1: begin
        if (accept) begin
          if (hdr_count > MAX_WORDS)    state_nx = ERR;
          else if (hdr_count == 17'd0)  state_nx = LOAD_END;
          else                          state_nx = DATA;
        end
      end
      DATA:  if (accept && byte_cnt == 2'd3) state_nx = WRITE;
      WRITE: state_nx = last_word ? LOAD_END : DATA;
`ifdef IMEM_CHECKSUM_EN
      CSUM: begin
        if (accept) state_nx = (bus.in_data == csum_q) ? DONE : ERR;
      end
`endif
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_lo <= 8'd0;
      count    <= 16'd0;
      word_q   <= 32'd0;
      word_idx <= '0;
      byte_cnt <= 2'd0;
`ifdef IMEM_CHECKSUM_EN
      csum_q   <= 8'd0;
`endif
    end else begin
`ifdef IMEM_CHECKSUM_EN
      if (accept) csum_q <= csum_q ^ bus.in_data;
`endif
      if (state == HDR0 && accept) count_lo <= bus.in_data;
      if (state == HDR1 && accept) count <= {bus.in_data, count_lo};
      if (state == DATA && accept) begin
        // Shift in from the top so the first byte ends up in [7:0].
        word_q   <= {bus.in_data, word_q[31:8]};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == WRITE) word_idx <= word_idx + IDX_ONE;
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory that the fetch path reads. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to consecutive word-aligned addresses through the instruction memory write port. It holds the processor in reset until the whole program is loaded. Instantiated at the top level, beside the instruction memory and ahead of the PC.

## Interface
- `ADDR_WIDTH`, default 6: word-address bits, giving 2^ADDR_WIDTH words of instruction memory.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the loader can accept a byte this cycle.
- `im_we` output 1: instruction memory write enable; one-cycle pulse per word.
- `im_addr` output 32: byte address of the write, always word-aligned (`[1:0]=0`), matching the PC address format.
- `im_wd` output 32: word to write.
- `cpu_reset` output 1: high while loading; holds PC and register state in reset.
- `done` output 1: load completed successfully.
- `error` output 1: load rejected.

## Operation
- A byte is accepted on a rising edge where `in_valid && in_ready`. No other byte is consumed.
- Stream format:
  - 2-byte header, little-endian word count N.
  - Then 4N data bytes; each word is little-endian, first byte to `[7:0]`.
  - Then, with `IMEM_CHECKSUM_EN` only, 1 checksum byte.
- FSM states: HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERR.
  - HDR0: accept the low count byte, then go to HDR1.
  - HDR1: accept the high count byte. Then:
    - If N > 2^ADDR_WIDTH, go to ERR.
    - Else if N = 0, go to CSUM (if enabled) or DONE.
    - Else go to DATA.
  - DATA: shift accepted bytes into the word register. A 2-bit byte counter advances per byte; on the 4th byte go to WRITE.
  - WRITE (1 cycle):
    - Outputs: `im_we=1`, `im_addr={word_idx,2'b00}` zero-extended to 32 bits, `im_wd`=assembled word.
    - Then increment `word_idx`.
    - If `word_idx == N-1`, go to CSUM (if enabled) or DONE; else go to DATA.
  - DONE and ERR are terminal; only `reset` leaves them.
- `in_ready` is 1 in HDR0, HDR1, DATA and CSUM. It is 0 in WRITE, DONE and ERR, and 0 in any cycle where `reset` is high.
- `im_we` is 1 only in WRITE.
- `cpu_reset` is 1 in every state except DONE.
- `done` is 1 only in DONE.
- `error` is 1 only in ERR.
- `word_idx` is ADDR_WIDTH+1 bits wide, so N = 2^ADDR_WIDTH is accepted without overflow.
- `in_valid` low stalls any accepting state indefinitely; no timeout.

## Timing
- Reset values (registered, effective the cycle after `reset` is sampled high):
  - state = HDR0, word register = 0, `word_idx` = 0, byte counter = 0.
  - `im_we=0`, `im_addr=0`, `im_wd=0`, `cpu_reset=1`, `done=0`, `error=0`.
- Reset mid-load: the sequence restarts at HDR0. Words already written stay in memory and are overwritten by the next load.
- Latency: the WRITE pulse occurs in the cycle after the 4th byte of a word is accepted. The earliest next byte is accepted one cycle later, so peak throughput is 4 bytes per 5 cycles.
- `done` rises, and `cpu_reset` falls, in the cycle after the final accepted byte or final WRITE. They fall and rise together on the same edge, with no gap.
- Outputs are registered or decoded from state only, with no combinational path from `in_valid` to `in_ready`.

## Configuration
- `IMEM_CHECKSUM_EN` defined:
  - The loader keeps a running XOR of every accepted byte, header included.
  - In CSUM it accepts one byte. If it equals the running XOR, go to DONE; otherwise go to ERR.
  - On mismatch the CPU stays held in reset; memory contents remain as written.
- `IMEM_CHECKSUM_EN` undefined:
  - The CSUM state and XOR register are absent.
  - After the last WRITE, or after HDR1 when N = 0, go directly to DONE.

## Test plan
- **Normal load.** Header 0x02,0x00, then bytes 0x13,0x00,0x00,0x20,0x44,0x33,0x22,0x11. Required: `im_we` pulses at `im_addr`=0x0 with `im_wd`=0x20000013, then at 0x4 with 0x11223344; `done`=1 and `cpu_reset`=0 one cycle later.
- **Backpressure and stalls.** Same stream with `in_valid` toggled randomly. Required: identical writes, and `in_ready`=0 in exactly the WRITE cycles.
- **Bounds, ADDR_WIDTH=6.** N=64 gives 64 writes, last at address 0xFC, then `done`. N=65 (0x41,0x00) gives `error`=1 after the header, no `im_we`, and `cpu_reset` stays 1.
- **Zero count.** N=0 gives `done` immediately after HDR1 (or after the checksum byte 0x00 when enabled), with no writes.
- **Reset mid-word.** Reset after 2 data bytes, then a full 1-word load of 0xDEADBEEF. Required: a single write at 0x0 of 0xDEADBEEF, with no partial-byte carryover.
- **Checksum (`IMEM_CHECKSUM_EN`).** 1-word load 0x00000001 with checksum byte 0x00 gives `done`. The same load with checksum byte 0x01 gives `error`=1 and `cpu_reset`=1.
